rr_mux_reg: RTL
===============

Name: rr_mux_reg

Overview:
- Parametrised N-channel, WIDTH-bit multiplexer with per-channel valid/ready handshakes, built-in arbitration and a one-entry registered output stage.
- Generalises the 2:1 combinational mux: channel count is a parameter, the selection is produced internally (round-robin or fixed priority) rather than driven by a sel input, and output transfers are flow-controlled.
- Sits between several producers and a single consumer, such as a shared bus or a downstream FIFO.

Parameters:
- WIDTH, 5, data width per channel (>=1).
- CHANNELS, 4, number of input channels (>=2; need not be a power of 2).
- RR_MODE, 1, arbitration mode: 1 = round-robin, 0 = fixed priority with the lowest index winning.
- Derived constant SEL_W = $clog2(CHANNELS), not user-set.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  CHANNELS  bit i: channel i has data.
- in_data  in  CHANNELS*WIDTH  channel i occupies in_data[i*WIDTH +: WIDTH].
- in_ready  out  CHANNELS  bit i: channel i transfers this cycle if in_valid[i]=1.
- out_valid  out  1  output register holds data.
- out_data  out  WIDTH  registered data.
- out_sel  out  SEL_W  index of the channel that supplied out_data.
- out_ready  in  1  consumer accepts out_data this cycle.

Behaviour:
- Reset (asynchronous, while rst_n=0):
  - out_valid=0, out_data=0, out_sel=0, priority pointer ptr=0.
  - in_ready is forced to all zeros while rst_n=0.
- Load enable: load_ok = !out_valid || out_ready. The register can accept a new word when it is empty, or when it is full and being consumed in the same cycle.
- Grant (combinational, computed every cycle from in_valid and ptr):
  - RR_MODE=1: the first i with in_valid[i]=1, searching ptr, ptr+1, ... and wrapping modulo CHANNELS.
  - RR_MODE=0: the lowest i with in_valid[i]=1; ptr is ignored.
  - No grant when in_valid is all zeros.
- in_ready[i] = load_ok && (i == grant) && (some in_valid is set). At most one bit of in_ready is ever high.
  - in_ready must not depend on in_data.
  - in_ready[g] may depend combinationally on in_valid and out_ready.
- Transfer, on the clock edge when in_valid[g] && in_ready[g]:
  - out_data <= in_data slice g; out_sel <= g; out_valid <= 1.
  - RR_MODE=1: ptr <= (g == CHANNELS-1) ? 0 : g+1. This wraps correctly for non-power-of-2 CHANNELS.
- Pop: out_valid && out_ready with no new transfer -> out_valid <= 0. out_data and out_sel keep their last values.
- Simultaneous pop and transfer: the register is overwritten and out_valid stays 1. Throughput is 1 word per cycle.
- Latency: 1 cycle from the input transfer edge to out_valid/out_data being visible.
- Backpressure: while out_valid=1 and out_ready=0, out_data and out_sel are held stable and in_ready is all zeros.
- ptr advances only on a transfer. It does not change while stalled or idle.
- Fairness: with every channel continuously valid in RR_MODE=1, each channel wins exactly once every CHANNELS transfers.
- A producer must hold in_valid and in_data stable until it transfers. The block does not check this.
- Reset asserted mid-operation: the held word is discarded at once (out_valid=0) and ptr returns to 0. Operation restarts from the reset state on the first edge after rst_n rises.
- No X on any output after reset, regardless of the in_data contents.

Test Plan:
1. Reset with all in_valid=1 -> during reset, in_ready=0 and out_valid=0. On the first edge after release, channel 0 transfers; out_data=in_data[0] and out_sel=0.
2. Default parameters, RR_MODE=1; in_data ch0..3 = 5'h15, 5'h0A, 5'h1F, 5'h01; all valid held, out_ready=1 -> out_sel sequence 0,1,2,3,0,1; out_data matches each channel; out_valid continuous, one word per cycle.
3. Only ch2 valid (5'h0A) with out_ready=0 for 3 cycles -> 1 transfer, then out_valid=1, out_data=5'h0A and out_sel=2 stable, in_ready=0000 for 3 cycles. After out_ready=1 with ch2 deasserted -> out_valid falls one cycle later.
4. RR_MODE=0, ch1 and ch3 continuously valid, out_ready=1 -> out_sel=1 every cycle; in_ready[3] never asserted (starvation by design).
5. CHANNELS=3, RR_MODE=1, all valid -> out_sel sequence 0,1,2,0,1,2 (wrap at a non-power-of-2). Then only ch0 valid after ch2 won -> ch0 granted immediately, next cycle.
6. Mid-stream reset while out_valid=1 with out_data=5'h1F -> out_valid=0 and out_data=0 asynchronously. After release, arbitration restarts from ch0 even if ptr was 2 before reset.

Source files
------------

// File: rtl/rr_mux_reg_if.sv
// Handshake bundle between N producers and one consumer around rr_mux_reg.
// The mux attaches through the slave modport; the traffic source/sink uses master.
interface rr_mux_reg_if #(
    parameter int WIDTH    = 5,
    parameter int CHANNELS = 4
);
    localparam int SEL_W = $clog2(CHANNELS);

    logic [CHANNELS-1:0]       in_valid;
    logic [CHANNELS*WIDTH-1:0] in_data;
    logic [CHANNELS-1:0]       in_ready;
    logic                      out_valid;
    logic [WIDTH-1:0]          out_data;
    logic [SEL_W-1:0]          out_sel;
    logic                      out_ready;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_sel
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_sel
    );
endinterface

// File: rtl/rr_mux_reg.sv
// N-channel valid/ready multiplexer with internal round-robin or fixed-priority
// arbitration feeding a single registered output slot (one word per cycle).
module rr_mux_reg #(
    parameter int WIDTH    = 5,
    parameter int CHANNELS = 4,
    parameter bit RR_MODE  = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    rr_mux_reg_if.slave bus
);
    localparam int SEL_W = $clog2(CHANNELS);

    logic [WIDTH-1:0] ch_data [CHANNELS];
    logic [SEL_W-1:0] rot_idx [CHANNELS];
    logic [SEL_W-1:0] ptr_reg;
    logic [SEL_W-1:0] ptr_next;
    logic [SEL_W-1:0] base;
    logic [SEL_W-1:0] grant;
    logic             any_valid;
    logic             load_ok;
    logic             xfer;
    logic             out_valid_reg;
    logic [WIDTH-1:0] out_data_reg;
    logic [SEL_W-1:0] out_sel_reg;

    // Fixed priority is round-robin with the search always starting at channel 0.
    assign base = RR_MODE ? ptr_reg : '0;

    // rot_idx[gi] is the channel examined at search position gi (base + gi mod CHANNELS).
    // The subtract-once wrap is enough because base < CHANNELS and gi < CHANNELS.
    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
        logic [SEL_W:0] sum;
        assign ch_data[gi] = bus.in_data[gi*WIDTH +: WIDTH];
        assign sum         = {1'b0, base} + (SEL_W+1)'(gi);
        assign rot_idx[gi] = (sum >= (SEL_W+1)'(CHANNELS))
                           ? SEL_W'(sum - (SEL_W+1)'(CHANNELS))
                           : sum[SEL_W-1:0];
        assign bus.in_ready[gi] = xfer && (grant == SEL_W'(gi));
    end

    // Scanning from the far end lets the earliest search position win without a break.
    always_comb begin
        grant     = '0;
        any_valid = 1'b0;
        for (int k = CHANNELS - 1; k >= 0; k--) begin
            if (bus.in_valid[rot_idx[k]]) begin
                grant     = rot_idx[k];
                any_valid = 1'b1;
            end
        end
    end

    assign load_ok  = !out_valid_reg || bus.out_ready;
    assign xfer     = rst_n && load_ok && any_valid;
    assign ptr_next = (grant == SEL_W'(CHANNELS - 1)) ? '0 : grant + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
            out_sel_reg   <= '0;
            ptr_reg       <= '0;
        end else if (xfer) begin
            out_valid_reg <= 1'b1;
            out_data_reg  <= ch_data[grant];
            out_sel_reg   <= grant;
            if (RR_MODE) begin
                ptr_reg <= ptr_next;
            end
        end else if (bus.out_ready) begin
            out_valid_reg <= 1'b0;
        end
    end

    assign bus.out_valid = out_valid_reg;
    assign bus.out_data  = out_data_reg;
    assign bus.out_sel   = out_sel_reg;
endmodule
